muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide engine feeding the EX stage's HI/LO path.
- Supports the full MULT/MULTU/MADD/MADDU/MSUB/MSUBU/DIV/DIVU set in one sequential datapath.
- Uses a start/busy/done handshake, so EX asserts stall_req while busy.
- Adds capabilities the EX stage does not have today: width parameter, accumulate done inside the unit, pipeline-flush abort, divide-by-zero flag.

Parameters:
- DATA_W, 32, operand width; result is 2*DATA_W as {hi,lo}.
- CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > DATA_W.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  op request; sampled only in IDLE
- op  input  3  0 MULTU, 1 MULT, 2 MADDU, 3 MADD, 4 MSUBU, 5 MSUB, 6 DIVU, 7 DIV
- op_a  input  DATA_W  multiplicand / dividend
- op_b  input  DATA_W  multiplier / divisor
- hilo_acc_in  input  2*DATA_W  forwarded {hi,lo} for MADD/MSUB, captured with start
- annul  input  1  flush; aborts any in-flight op
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse; res is valid when high
- res  output  2*DATA_W  mul: product/accumulated value; div: {remainder, quotient}
- div_zero  output  1  set with done when a divide had op_b == 0

Behaviour:
- Reset (async, rst_n low): state IDLE, busy=0, done=0, div_zero=0, res=0; counter and internal registers cleared. Reset mid-operation abandons the op; no done is produced.
- States: IDLE, CALC, FIX, DONE.
- IDLE: when start=1 and annul=0:
  - capture op, operand magnitudes, sign flags and hilo_acc_in;
  - go to CALC with counter = 0.
  - Exception: divide with op_b == 0 goes straight to DONE.
- CALC, multiply: one shift-add step per cycle; DATA_W cycles, counter increments each cycle; then FIX.
- CALC, divide: one restoring-division step per cycle; DATA_W cycles; then FIX.
- FIX (1 cycle):
  - Signed ops: negate the product when sign(a) != sign(b).
  - Quotient is negated when signs differ. Remainder takes the sign of the dividend.
  - MADD*: res_next = acc + product. MSUB*: res_next = acc - product. Both are 2*DATA_W modular arithmetic with no overflow flag.
  - Then go to DONE.
- DONE (1 cycle): done=1, res updated; return to IDLE. div_zero=1 only for a divide-by-zero, otherwise 0.
- Latency:
  - Normal op: done is high in the cycle after edge start+DATA_W+1, i.e. DATA_W+2 cycles after the start edge. Back-to-back start is accepted in the cycle after done.
  - Divide-by-zero: done is high 1 cycle after the start edge, res = {op_a, all ones}.
- Signed edge case: DIV of most-negative by -1 gives quotient = most-negative (wraps), remainder = 0, div_zero=0.
- Handshakes and hazards:
  - start while busy is ignored; the in-flight op is unaffected.
  - start and annul high in the same cycle in IDLE: annul wins, nothing starts.
  - annul in CALC/FIX/DONE: synchronously return to IDLE next edge, done is suppressed, res keeps its previous value.
  - res holds its value from done until the next completed op. Inputs other than start/annul are don't-care while busy.
  - Unsigned ops never apply sign correction, even when the MSB is set.

Test Plan (DATA_W=32):
- MULT a=0xFFFFFFFE, b=3 -> done exactly 34 cycles after start edge, res=0xFFFFFFFF_FFFFFFFA; MULTU a=b=0xFFFFFFFF -> res=0xFFFFFFFE_00000001.
- MADD acc=0x00000000_00000010, a=0xFFFFFFFE, b=4 -> res=0x00000000_00000008; MSUBU acc=0, a=1, b=1 -> res=0xFFFFFFFF_FFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 -> res={0xFFFFFFFF, 0xFFFFFFFD}; DIVU a=7, b=2 -> {1, 3}; DIV 0x80000000 / 0xFFFFFFFF -> {0, 0x80000000}, div_zero=0.
- DIVU a=7, b=0 -> done 1 cycle after start, div_zero=1, res={0x00000007, 0xFFFFFFFF}; next MULTU -> div_zero=0 on its done.
- Start MULT, assert annul 10 cycles in -> busy=0 next cycle, no done pulse, res unchanged; start pulse during busy ignored; start+annul in IDLE -> busy stays 0.
- Drop rst_n asynchronously mid-CALC -> busy/done/res/div_zero go to 0 immediately; after release a fresh DIVU 100/7 gives {2, 14} with normal latency.

Source files
------------

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative multiply/accumulate/divide engine with start/busy/done handshake
// One shift-add or restoring-divide step per cycle on operand magnitudes; signs fixed up at the end.
module muldiv_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_W-1:0]     op_a,
  input  logic [DATA_W-1:0]     op_b,
  input  logic [2*DATA_W-1:0]   hilo_acc_in,
  input  logic                  annul,
  output logic                  busy,
  output logic                  done,
  output logic [2*DATA_W-1:0]   res,
  output logic                  div_zero
);

  localparam int W2 = 2 * DATA_W;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, state_nxt;

  logic [2:0]          op_q;
  logic [DATA_W-1:0]   mag_a, mag_b;
  logic                neg_a, neg_b, dz;
  logic [W2-1:0]       acc, p, res_q;
  logic [CNT_W-1:0]    cnt;

  // op[0] marks every signed opcode, op[2:1]==3 marks the divides
  logic                is_div_in, b_zero;
  logic [DATA_W-1:0]   a_mag_in, b_mag_in;
  assign is_div_in = op[2] & op[1];
  assign b_zero    = (op_b == '0);
  assign a_mag_in  = (op[0] && op_a[DATA_W-1]) ? -op_a : op_a;
  assign b_mag_in  = (op[0] && op_b[DATA_W-1]) ? -op_b : op_b;

  logic is_div_q, sgn_q;
  assign is_div_q = op_q[2] & op_q[1];
  assign sgn_q    = op_q[0];

  // Multiply: p = {partial hi, remaining multiplier bits}, shifted right each step
  logic [DATA_W:0] mul_sum;
  logic [W2-1:0]   mul_next;
  assign mul_sum  = {1'b0, p[W2-1:DATA_W]} + (p[0] ? {1'b0, mag_a} : {(DATA_W+1){1'b0}});
  assign mul_next = {mul_sum, p[DATA_W-1:1]};

  // Divide: p = {partial remainder, dividend bits becoming quotient bits}
  logic [DATA_W:0] div_shift, div_diff;
  logic [W2-1:0]   div_next;
  assign div_shift = {p[W2-1:DATA_W], p[DATA_W-1]};
  assign div_diff  = div_shift - {1'b0, mag_b};
  assign div_next  = div_diff[DATA_W] ? {div_shift[DATA_W-1:0], p[DATA_W-2:0], 1'b0}
                                      : {div_diff[DATA_W-1:0],  p[DATA_W-2:0], 1'b1};

  logic [W2-1:0]     prod, mul_fix, div_fix, fix_val;
  logic [DATA_W-1:0] quo, rem;
  assign prod    = (sgn_q && (neg_a ^ neg_b)) ? -p : p;
  assign mul_fix = (op_q[2:1] == 2'd1) ? acc + prod :
                   (op_q[2:1] == 2'd2) ? acc - prod : prod;
  assign quo     = (sgn_q && (neg_a ^ neg_b)) ? -p[DATA_W-1:0] : p[DATA_W-1:0];
  assign rem     = (sgn_q && neg_a) ? -p[W2-1:DATA_W] : p[W2-1:DATA_W];
  assign div_fix = {rem, quo};
  assign fix_val = is_div_q ? div_fix : mul_fix;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && !annul) state_nxt = (is_div_in && b_zero) ? DONE : CALC;
      CALC: if (annul) state_nxt = IDLE;
            else if (cnt == CNT_W'(DATA_W - 1)) state_nxt = FIX;
      FIX:  state_nxt = annul ? IDLE : DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= '0;
      mag_a <= '0;
      mag_b <= '0;
      neg_a <= 1'b0;
      neg_b <= 1'b0;
      dz    <= 1'b0;
      acc   <= '0;
      p     <= '0;
      cnt   <= '0;
      res_q <= '0;
    end else begin
      case (state)
        IDLE: if (start && !annul) begin
          op_q  <= op;
          mag_a <= a_mag_in;
          mag_b <= b_mag_in;
          neg_a <= op[0] & op_a[DATA_W-1];
          neg_b <= op[0] & op_b[DATA_W-1];
          acc   <= hilo_acc_in;
          cnt   <= '0;
          dz    <= is_div_in & b_zero;
          if (is_div_in) p <= b_zero ? {op_a, {DATA_W{1'b1}}} : {{DATA_W{1'b0}}, a_mag_in};
          else           p <= {{DATA_W{1'b0}}, b_mag_in};
        end
        CALC: begin
          p   <= is_div_q ? div_next : mul_next;
          cnt <= cnt + CNT_W'(1);
        end
        FIX:  p <= fix_val;
        DONE: if (!annul) res_q <= p;
        default: ;
      endcase
    end
  end

  // res shows the fresh result during the done cycle, then holds it
  assign busy     = (state != IDLE);
  assign done     = (state == DONE) && !annul;
  assign div_zero = done && dz;
  assign res      = (state == DONE) ? p : res_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] op_a = '0, op_b = '0;
  logic [63:0] hilo_acc_in = '0;
  logic        annul = 1'b0;
  logic        busy, done, div_zero;
  logic [63:0] res;

  int total = 0;
  int bad = 0;

  muldiv_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
    .hilo_acc_in(hilo_acc_in), .annul(annul), .busy(busy), .done(done),
    .res(res), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  // Starts one op in an IDLE cycle and waits (bounded) for done.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] acc, output logic [63:0] r, output logic dzf,
                        output int lat);
    @(negedge clk);
    op = o; op_a = a; op_b = b; hilo_acc_in = acc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    r = res;
    dzf = div_zero;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", done); end
    total++; if (res !== 64'd0) begin bad++; $display("FAIL reset_res got=%h want=0", res); end
    total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL reset_dz got=%0b want=0", div_zero); end
    rst_n = 1'b1;
  endtask

  task automatic test_mul;
    logic [63:0] r; logic dzf; int lat;
    run_op(3'd1, 32'hFFFFFFFE, 32'd3, 64'd0, r, dzf, lat);
    total++; if (lat !== 34) begin bad++; $display("FAIL mult_latency got=%0d want=34", lat); end
    total++; if (r !== 64'hFFFFFFFF_FFFFFFFA) begin bad++; $display("FAIL mult_res got=%h want=fffffffffffffffa", r); end
    run_op(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd0, r, dzf, lat);
    total++; if (r !== 64'hFFFFFFFE_00000001) begin bad++; $display("FAIL multu_res got=%h want=fffffffe00000001", r); end
    @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL idle_after_done busy=%0b done=%0b want 0/0", busy, done); end
  endtask

  task automatic test_acc;
    logic [63:0] r; logic dzf; int lat;
    run_op(3'd3, 32'hFFFFFFFE, 32'd4, 64'h10, r, dzf, lat);
    total++; if (r !== 64'h8) begin bad++; $display("FAIL madd_res got=%h want=8", r); end
    run_op(3'd4, 32'd1, 32'd1, 64'd0, r, dzf, lat);
    total++; if (r !== 64'hFFFFFFFF_FFFFFFFF) begin bad++; $display("FAIL msubu_res got=%h want=ffffffffffffffff", r); end
  endtask

  task automatic test_div;
    logic [63:0] r; logic dzf; int lat;
    run_op(3'd7, 32'hFFFFFFF9, 32'd2, 64'd0, r, dzf, lat);
    total++; if (r !== 64'hFFFFFFFF_FFFFFFFD) begin bad++; $display("FAIL div_neg_res got=%h want=fffffffffffffffd", r); end
    run_op(3'd6, 32'd7, 32'd2, 64'd0, r, dzf, lat);
    total++; if (r !== 64'h00000001_00000003) begin bad++; $display("FAIL divu_res got=%h want=0000000100000003", r); end
    total++; if (lat !== 34) begin bad++; $display("FAIL divu_latency got=%0d want=34", lat); end
    run_op(3'd7, 32'h80000000, 32'hFFFFFFFF, 64'd0, r, dzf, lat);
    total++; if (r !== 64'h00000000_80000000 || dzf !== 1'b0) begin bad++; $display("FAIL div_minneg got=%h dz=%0b want=0000000080000000 dz=0", r, dzf); end
  endtask

  task automatic test_div_zero;
    logic [63:0] r; logic dzf; int lat;
    run_op(3'd6, 32'd7, 32'd0, 64'd0, r, dzf, lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL divz_latency got=%0d want=1", lat); end
    total++; if (dzf !== 1'b1) begin bad++; $display("FAIL divz_flag got=%0b want=1", dzf); end
    total++; if (r !== 64'h00000007_FFFFFFFF) begin bad++; $display("FAIL divz_res got=%h want=00000007ffffffff", r); end
    run_op(3'd0, 32'd3, 32'd5, 64'd0, r, dzf, lat);
    total++; if (dzf !== 1'b0 || r !== 64'd15) begin bad++; $display("FAIL after_divz got=%h dz=%0b want=f dz=0", r, dzf); end
  endtask

  task automatic test_annul;
    logic [63:0] r; logic dzf; int lat;
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    op = 3'd1; op_a = 32'd9; op_b = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_in_calc got=%0b want=1", busy); end
    annul = 1'b1;
    @(negedge clk);
    annul = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL annul_busy got=%0b want=0", busy); end
    total++; if (res !== 64'd15) begin bad++; $display("FAIL annul_res got=%h want=f", res); end
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL annul_no_done got=%0b want=0", seen); end

    // a second start while busy must not disturb the running MULTU
    @(negedge clk);
    op = 3'd0; op_a = 32'd2; op_b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
      if (lat == 5) begin op = 3'd6; op_a = 32'd100; op_b = 32'd0; start = 1'b1; end
      if (lat == 6) start = 1'b0;
    end
    total++; if (lat !== 34 || res !== 64'd6 || div_zero !== 1'b0)
      begin bad++; $display("FAIL start_while_busy lat=%0d res=%h dz=%0b want 34/6/0", lat, res, div_zero); end

    @(negedge clk);
    op = 3'd0; start = 1'b1; annul = 1'b1;
    @(negedge clk);
    start = 1'b0; annul = 1'b0;
    seen = busy;
    repeat (3) begin
      @(negedge clk);
      if (busy || done) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL start_annul_idle busy_or_done=%0b want=0", seen); end
    r = '0; dzf = 1'b0;
  endtask

  task automatic test_async_reset;
    logic [63:0] r; logic dzf; int lat;
    @(negedge clk);
    op = 3'd1; op_a = 32'd5; op_b = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || done !== 1'b0 || res !== 64'd0 || div_zero !== 1'b0)
      begin bad++; $display("FAIL async_reset busy=%0b done=%0b res=%h dz=%0b want all 0", busy, done, res, div_zero); end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'd6, 32'd100, 32'd7, 64'd0, r, dzf, lat);
    total++; if (lat !== 34 || r !== 64'h00000002_0000000E)
      begin bad++; $display("FAIL divu_after_reset lat=%0d res=%h want 34/000000020000000e", lat, r); end
  endtask

  task automatic test_back_to_back;
    logic [63:0] r; logic dzf; int lat;
    run_op(3'd0, 32'h00010000, 32'h00010000, 64'd0, r, dzf, lat);
    total++; if (lat !== 34 || r !== 64'h00000001_00000000)
      begin bad++; $display("FAIL b2b_first lat=%0d res=%h want 34/0000000100000000", lat, r); end
    run_op(3'd7, 32'd100, 32'hFFFFFFF9, 64'd0, r, dzf, lat);
    total++; if (lat !== 34 || r !== 64'h00000002_FFFFFFF2)
      begin bad++; $display("FAIL b2b_second lat=%0d res=%h want 34/00000002fffffff2", lat, r); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_acc();
    test_div();
    test_div_zero();
    test_annul();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
